// File: rtl/bcd_xs3_seq_ctrl.sv
// Multi-digit BCD to Excess-3 sequencing controller.
// A captured DIGITS-wide BCD word is pushed through one shared nibble
// converter (digit+3), one digit per clock, LSD first. The assembled
// Excess-3 word is offered on a valid/ready output; any digit above 9 is
// written as 4'h0 and raises the sticky out_err flag for that word.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous abort back to IDLE (wins over capture)
//   in_valid/in_ready   input handshake, in_ready only in IDLE
//   in_bcd              packed BCD word, digit 0 in bits [3:0]
//   out_valid/out_ready output handshake, out_valid only in DONE
//   out_xs3, out_err    Excess-3 result and non-BCD flag
//   busy                high in CONV or DONE
module bcd_xs3_seq_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_xs3,
    output logic                  out_err,
    output logic                  busy
);

    localparam int unsigned DATA_W = 4 * DIGITS;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned OFF_W  = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   word;

    logic [OFF_W-1:0]    off_c;
    logic [3:0]          digit_c;
    logic [3:0]          xs3_c;
    logic                bad_c;

    // Shared nibble converter fed by the current digit index
    always_comb begin
        off_c   = {idx, 2'b00};
        digit_c = word[off_c +: 4];
        bad_c   = (digit_c > 4'd9);
        xs3_c   = bad_c ? 4'h0 : 4'(digit_c + 4'd3);
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            word      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_xs3   <= '0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            idx       <= '0;
            word      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_xs3   <= '0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= CONV;
                        word     <= in_bcd;
                        idx      <= '0;
                        out_xs3  <= '0;
                        out_err  <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CONV: begin
                    out_xs3[off_c +: 4] <= xs3_c;
                    if (bad_c) begin
                        out_err <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    // Result stays put until the consumer takes it
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        idx       <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
